// File: rtl/uart_hex_scan_if.sv
// Byte-capture and scan-output bundle between the UART display path and the hex scanner.
interface uart_hex_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  clear;
  logic [3:0]            dec_code;
  logic [NUM_DIGITS-1:0] dig_en;
  logic [7:0]            byte_cnt;

  modport master (
    output rx_data, rx_valid, clear,
    input  dec_code, dig_en, byte_cnt
  );

  modport slave (
    input  rx_data, rx_valid, clear,
    output dec_code, dig_en, byte_cnt
  );
endinterface

// File: rtl/uart_hex_scan.sv
// Buffers received bytes and time-multiplexes them as hex glyph codes across NUM_DIGITS digits.
// Optional macro SCAN_GHOST_BLANK_EN blanks dig_en for the first 4 cycles of every slot.
module uart_hex_scan #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned NUM_DIGITS = 4
) (
  input logic            clk,
  input logic            rst,
  uart_hex_scan_if.slave bus
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BW = NUM_DIGITS * 4;

  logic [BW-1:0]         buf_q,   buf_d;
  logic [NUM_DIGITS-1:0] mask_q,  mask_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q,   idx_d;
  logic [7:0]            cnt_q,   cnt_d;
  logic [3:0]            code_q,  code_d;
  logic [NUM_DIGITS-1:0] en_q,    en_d;
  logic [3:0]            nib;

  // Hex nibble to decoder glyph code; digits 0-9 pass straight through.
  function automatic logic [3:0] glyph(input logic [3:0] n);
    case (n)
      4'hA:    glyph = 4'hB;
      4'hB:    glyph = 4'hD;
      4'hC:    glyph = 4'hA;
      4'hD:    glyph = 4'hF;
      4'hE:    glyph = 4'hE;
      4'hF:    glyph = 4'hC;
      default: glyph = n;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      mask_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      en_q    <= '0;
    end else begin
      buf_q   <= buf_d;
      mask_q  <= mask_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    buf_d   = buf_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    nib     = 4'(buf_q >> {idx_q, 2'b00});
    code_d  = glyph(nib);
    en_d    = '0;

    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    // Clear beats a same-cycle byte; each rx_valid cycle shifts in one byte.
    if (bus.clear) begin
      buf_d  = '0;
      mask_d = '0;
      cnt_d  = '0;
    end else if (bus.rx_valid) begin
      buf_d  = (buf_q << 8) | BW'(bus.rx_data);
      mask_d = (mask_q << 2) | NUM_DIGITS'(2'b11);
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    if (mask_q[idx_q]) en_d = NUM_DIGITS'(1) << idx_q;
`ifdef SCAN_GHOST_BLANK_EN
    if (presc_q < PW'(4)) en_d = '0;
`else
`endif
  end

  assign bus.dec_code = code_q;
  assign bus.dig_en   = en_q;
  assign bus.byte_cnt = cnt_q;

endmodule

// File: tb/tb_uart_hex_scan.sv
// Scoreboard bench for uart_hex_scan: expectations are queued per cycle and checked by a monitor.
module tb_uart_hex_scan;

  localparam int unsigned SCAN_DIV   = 8;
  localparam int unsigned NUM_DIGITS = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  code;
    logic [3:0]  en;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_n;

  uart_hex_scan_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

  uart_hex_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .NUM_DIGITS(NUM_DIGITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; output at cycle k shows slot ((k-1)/8)%4.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Expected dig_en with the optional first-4-cycles blanking applied.
  function automatic logic [3:0] ge(input int k, input logic [3:0] en);
`ifdef SCAN_GHOST_BLANK_EN
    if (((k - 1) % 8) < 4) return 4'b0000;
`else
`endif
    return en;
  endfunction

  task automatic check(input string n, input logic [3:0] code, input logic [3:0] en,
                       input logic [7:0] cnt, input exp_t e);
    checks++;
    if (code !== e.code || en !== e.en || cnt !== e.cnt) begin
      failures++;
      $display("FAIL %s @cyc %0d: got code=%h en=%b cnt=%0d, want code=%h en=%b cnt=%0d",
               n, cyc, code, en, cnt, e.code, e.en, e.cnt);
    end
  endtask

  task automatic push(input string n, input int c, input logic [3:0] code,
                      input logic [3:0] en, input logic [7:0] cnt);
    exp_t e;
    e.cyc  = 32'(c);
    e.code = code;
    e.en   = en;
    e.cnt  = cnt;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Monitor: pops every expectation due at this cycle and compares the DUT outputs.
  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if (int'(mon_e.cyc) < cyc) begin
          checks++;
          failures++;
          $display("FAIL %s: missed, due cyc %0d, now %0d", mon_n, mon_e.cyc, cyc);
        end else begin
          check(mon_n, bus.dec_code, bus.dig_en, bus.byte_cnt, mon_e);
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    int g;
    g = 0;
    forever begin
      @(negedge clk);
      g++;
      if (cyc >= t || g > 5000) break;
    end
    if (cyc != t) begin
      checks++;
      failures++;
      $display("FAIL wait_cyc: got cyc %0d, want %0d", cyc, t);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    exp_t z;
    z = '0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.clear    = 1'b0;

    // Idle after reset: nothing valid, code 0, no enables.
    do_reset();
    for (int k = 1; k <= 64; k++) push("idle", k, 4'h0, 4'b0000, 8'd0);
    wait_cyc(64);
    drain();

    // Single byte 3A captured at edge 3.
    do_reset();
    push("b3a_lat",  3, 4'h0, 4'b0000,         8'd1);
    push("b3a_d0a",  4, 4'hB, ge(4, 4'b0001),  8'd1);
    push("b3a_d0b",  6, 4'hB, ge(6, 4'b0001),  8'd1);
    push("b3a_d1",  14, 4'h3, ge(14, 4'b0010), 8'd1);
    push("b3a_d2",  22, 4'h0, 4'b0000,         8'd1);
    push("b3a_d3",  30, 4'h0, 4'b0000,         8'd1);
    push("b3a_wrap", 38, 4'hB, ge(38, 4'b0001), 8'd1);
    wait_cyc(2);
    bus.rx_data = 8'h3A; bus.rx_valid = 1'b1;
    wait_cyc(3);
    bus.rx_valid = 1'b0;
    wait_cyc(40);
    drain();

    // Three bytes 12, CF, DE at edges 2..4 (12 falls out), then clear+rx at edge 32.
    do_reset();
    push("seq_mid",  3, 4'h2, ge(3, 4'b0001),  8'd2);
    push("seq_d0",   6, 4'hE, ge(6, 4'b0001),  8'd3);
    push("seq_d1",  14, 4'hF, ge(14, 4'b0010), 8'd3);
    push("seq_d2",  22, 4'hC, ge(22, 4'b0100), 8'd3);
    push("seq_d3",  30, 4'hA, ge(30, 4'b1000), 8'd3);
    push("clr_cnt", 32, 4'hA, ge(32, 4'b1000), 8'd0);
    push("clr_d0",  38, 4'h0, 4'b0000, 8'd0);
    push("clr_d1",  46, 4'h0, 4'b0000, 8'd0);
    push("clr_d2",  54, 4'h0, 4'b0000, 8'd0);
    push("clr_d3",  62, 4'h0, 4'b0000, 8'd0);
    wait_cyc(1);
    bus.rx_data = 8'h12; bus.rx_valid = 1'b1;
    wait_cyc(2);
    bus.rx_data = 8'hCF;
    wait_cyc(3);
    bus.rx_data = 8'hDE;
    wait_cyc(4);
    bus.rx_valid = 1'b0;
    wait_cyc(31);
    bus.rx_data = 8'h55; bus.rx_valid = 1'b1; bus.clear = 1'b1;
    wait_cyc(32);
    bus.rx_valid = 1'b0; bus.clear = 1'b0;
    wait_cyc(64);
    drain();

    // rx_valid held for 300 edges with A7: byte_cnt saturates at 255.
    do_reset();
    bus.rx_data = 8'hA7; bus.rx_valid = 1'b1;
    push("sat_254", 254, 4'hB, ge(254, 4'b1000), 8'd254);
    push("sat_255", 255, 4'hB, ge(255, 4'b1000), 8'd255);
    push("sat_256", 256, 4'hB, ge(256, 4'b1000), 8'd255);
    push("sat_300", 300, 4'hB, ge(300, 4'b0010), 8'd255);
    push("sat_310", 310, 4'h7, ge(310, 4'b0100), 8'd255);
    wait_cyc(300);
    bus.rx_valid = 1'b0;
    wait_cyc(312);
    drain();

    // Async reset mid-slot (prescaler 5), then slot timing restarts from zero.
    do_reset();
    bus.rx_data = 8'h3A; bus.rx_valid = 1'b1;
    wait_cyc(1);
    bus.rx_valid = 1'b0;
    push("pre_rst", 13, 4'h3, ge(13, 4'b0010), 8'd1);
    wait_cyc(13);
    #2 rst = 1'b1;
    #1 check("rst_async", bus.dec_code, bus.dig_en, bus.byte_cnt, z);
    @(negedge clk);
    rst = 1'b0;
    bus.rx_data = 8'h3A; bus.rx_valid = 1'b1;
    for (int k = 2; k <= 8; k++) push("post_d0", k, 4'hB, ge(k, 4'b0001), 8'd1);
    push("post_adv", 9, 4'h3, ge(9, 4'b0010), 8'd1);
    wait_cyc(1);
    bus.rx_valid = 1'b0;
    wait_cyc(10);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at cyc %0d, want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
